// File: rtl/sonar_pw_emulator.sv
// Avalon-MM programmable emulator of a sonar rangefinder pulse-width echo output.
// Define SONAR_EMU_NOISE_EN to add LFSR jitter (0..255 cycles) to each pulse's high time.
module sonar_pw_emulator #(
    parameter int unsigned CLKS_PER_INCH  = 7350,
    parameter int unsigned DEFAULT_PERIOD = 2450000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        sonar_pw,
    output logic        frame_start
);
`ifdef SONAR_EMU_NOISE_EN
    localparam int unsigned NOISE_MAX = 255;
`else
    localparam int unsigned NOISE_MAX = 0;
`endif
    localparam int unsigned HIGH_MAX = 254 * CLKS_PER_INCH + NOISE_MAX;
    localparam int unsigned HW       = $clog2(HIGH_MAX + 1);
    localparam int unsigned DW       = 9;
    localparam int unsigned FW       = 32;
    localparam logic [DW-1:0] DIST_MIN = 9'd6;
    localparam logic [DW-1:0] DIST_MAX = 9'd254;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t        state;
    logic          ctrl_enable;
    logic          ctrl_oneshot;
    logic [DW-1:0] distance;
    logic [DW-1:0] shadow_distance;
    logic [31:0]   period;
    logic [31:0]   shadow_period;
    logic [15:0]   frame_count;
    logic [HW-1:0] high_cnt;
    logic [HW-1:0] high_cycles;
    logic [HW-1:0] high_last;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_min;
    logic [FW-1:0] frame_last;
    logic          wr_ctrl;
    logic          abort;
    logic          frame_done;
    logic          start_frame;
    logic [DW-1:0] dist_clamped;
    logic [31:0]   rd_mux;
`ifdef SONAR_EMU_NOISE_EN
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [7:0]    shadow_noise;
`endif

    // Frame timing derived from the per-frame shadows, plus register decode.
    always_comb begin
        wr_ctrl     = avs_write && (avs_address == 2'd0);
        abort       = wr_ctrl && !avs_writedata[0];
        high_cycles = HW'(shadow_distance) * HW'(CLKS_PER_INCH);
`ifdef SONAR_EMU_NOISE_EN
        high_cycles = high_cycles + HW'(shadow_noise);
        lfsr_next   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
        high_last   = high_cycles - HW'(1);
        frame_min   = FW'(high_cycles) + FW'(1);
        frame_last  = ((shadow_period > frame_min) ? shadow_period : frame_min) - FW'(1);
        frame_done  = (state == LOW) && (frame_cnt >= frame_last);
        start_frame = !abort && (((state == IDLE) && ctrl_enable) ||
                                 (frame_done && !ctrl_oneshot));

        if (avs_writedata < 32'd6) begin
            dist_clamped = DIST_MIN;
        end else if (avs_writedata > 32'd254) begin
            dist_clamped = DIST_MAX;
        end else begin
            dist_clamped = avs_writedata[DW-1:0];
        end

        case (avs_address)
            2'd0:    rd_mux = {30'd0, ctrl_oneshot, ctrl_enable};
            2'd1:    rd_mux = {23'd0, distance};
            2'd2:    rd_mux = period;
            default: rd_mux = {frame_count, 15'd0, (state != IDLE)};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            sonar_pw        <= 1'b0;
            frame_start     <= 1'b0;
            avs_readdata    <= '0;
            ctrl_enable     <= 1'b0;
            ctrl_oneshot    <= 1'b0;
            distance        <= DIST_MIN;
            period          <= 32'(DEFAULT_PERIOD);
            frame_count     <= '0;
            shadow_distance <= '0;
            shadow_period   <= '0;
            high_cnt        <= '0;
            frame_cnt       <= '0;
`ifdef SONAR_EMU_NOISE_EN
            lfsr            <= 16'hACE1;
            shadow_noise    <= '0;
`endif
        end else begin
            frame_start <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                sonar_pw <= 1'b0;
            end else if (start_frame) begin
                state           <= HIGH;
                sonar_pw        <= 1'b1;
                frame_start     <= 1'b1;
                frame_count     <= frame_count + 16'd1;
                shadow_distance <= distance;
                shadow_period   <= period;
                high_cnt        <= '0;
                frame_cnt       <= '0;
`ifdef SONAR_EMU_NOISE_EN
                lfsr            <= lfsr_next;
                shadow_noise    <= lfsr_next[7:0];
`endif
            end else begin
                case (state)
                    HIGH: begin
                        frame_cnt <= frame_cnt + FW'(1);
                        if (high_cnt == high_last) begin
                            state    <= LOW;
                            sonar_pw <= 1'b0;
                        end else begin
                            high_cnt <= high_cnt + HW'(1);
                        end
                    end
                    LOW: begin
                        // Reaching frame end here without a restart means one-shot mode.
                        if (frame_done) begin
                            state        <= IDLE;
                            ctrl_enable  <= 1'b0;
                            ctrl_oneshot <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                    default: ;
                endcase
            end

            if (avs_write) begin
                case (avs_address)
                    2'd0: begin
                        ctrl_enable  <= avs_writedata[0];
                        ctrl_oneshot <= avs_writedata[1];
                    end
                    2'd1:    distance <= dist_clamped;
                    2'd2:    period   <= avs_writedata;
                    default: ;
                endcase
            end

            avs_readdata <= avs_read ? rd_mux : '0;
        end
    end
endmodule

// File: tb/tb_sonar_pw_emulator.sv
// Directed scoreboard bench for sonar_pw_emulator (CLKS_PER_INCH=10, DEFAULT_PERIOD=200).
module tb_sonar_pw_emulator;
    localparam int unsigned CPI   = 10;
    localparam int unsigned DP    = 200;
    localparam int          LIMIT = 6000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        sonar_pw;
    logic        frame_start;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    sonar_pw_emulator #(.CLKS_PER_INCH(CPI), .DEFAULT_PERIOD(DP)) dut (
        .clk          (clk),
        .reset        (reset),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .sonar_pw     (sonar_pw),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed %0d with empty scoreboard", tag, obs);
        end else begin
            want = exp_q.pop_front();
            assert (obs === want) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", tag, obs, want);
            end
        end
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    // Measures one frame from its frame_start to the next; optionally writes a register mid-frame.
    task automatic measure_frame(input bit do_wr, input int wr_at, input logic [1:0] wa,
                                 input logic [31:0] wd, output int hi, output int len);
        int w;
        w   = 0;
        hi  = 0;
        len = 0;
        while (!frame_start && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        do begin
            avs_write = do_wr && (len == wr_at);
            if (avs_write) begin
                avs_address   = wa;
                avs_writedata = wd;
            end
            if (sonar_pw) hi++;
            len++;
            @(negedge clk);
        end while (!frame_start && len < LIMIT);
        avs_write = 1'b0;
    endtask

    task automatic window(input int n, output int hi, output int fs);
        hi = 0;
        fs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sonar_pw) hi++;
            if (frame_start) fs++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] model;
        int          hi;
        int          len;
        int          fs;
        int          want_hi;

        reset         = 1'b1;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        repeat (3) @(negedge clk);
        push(0); check("reset_pw", 32'(sonar_pw));
        push(0); check("reset_fs", 32'(frame_start));
        push(0); check("reset_rdata", avs_readdata);
        reset = 1'b0;

        push(0);   avs_rd(2'd0, rd); check("reset_ctrl", rd);
        push(6);   avs_rd(2'd1, rd); check("reset_dist", rd);
        push(DP);  avs_rd(2'd2, rd); check("reset_period", rd);
        push(0);   avs_rd(2'd3, rd); check("reset_status", rd);

        avs_wr(2'd1, 32'd2);   push(6);   avs_rd(2'd1, rd); check("clamp_low", rd);
        avs_wr(2'd1, 32'd300); push(254); avs_rd(2'd1, rd); check("clamp_high", rd);
        avs_wr(2'd3, 32'hFFFF_FFFF); push(0); avs_rd(2'd3, rd); check("status_ro", rd);

        // Continuous 10-inch frames.
        avs_wr(2'd1, 32'd10);
        avs_wr(2'd0, 32'd1);
        for (int f = 0; f < 2; f++) begin
            push(100); push(200);
            measure_frame(1'b0, 0, 2'd0, 32'd0, hi, len);
            check("run_high", 32'(hi));
            check("run_len", 32'(len));
        end

        // Distance change during HIGH applies to the following frame only.
        push(100); push(200);
        measure_frame(1'b1, 50, 2'd1, 32'd20, hi, len);
        check("midwr_cur_high", 32'(hi));
        check("midwr_cur_len", 32'(len));
        push(200); push(201);
        measure_frame(1'b0, 0, 2'd0, 32'd0, hi, len);
        check("midwr_next_high", 32'(hi));
        check("midwr_next_len", 32'(len));

        // Abort 50 cycles into the fifth frame's HIGH.
        repeat (50) @(negedge clk);
        push(1); check("abort_pre_pw", 32'(sonar_pw));
        avs_address   = 2'd0;
        avs_writedata = 32'd0;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        push(0); check("abort_pw", 32'(sonar_pw));
        push(32'd5 << 16); avs_rd(2'd3, rd); check("abort_status", rd);
        window(300, hi, fs);
        push(0); check("abort_quiet_pw", 32'(hi));
        push(0); check("abort_quiet_fs", 32'(fs));

        // One-shot frame.
        avs_wr(2'd1, 32'd10);
        avs_wr(2'd0, 32'd3);
        window(400, hi, fs);
        push(100); check("oneshot_high", 32'(hi));
        push(1);   check("oneshot_fs", 32'(fs));
        push(0);   avs_rd(2'd0, rd); check("oneshot_ctrl", rd);
        push(32'd6 << 16); avs_rd(2'd3, rd); check("oneshot_status", rd);

        // Maximum distance: frame stretches to high time + 1.
        avs_wr(2'd1, 32'd254);
        avs_wr(2'd2, 32'd200);
        avs_wr(2'd0, 32'd1);
        push(2540); push(2541);
        measure_frame(1'b0, 0, 2'd0, 32'd0, hi, len);
        check("max_high", 32'(hi));
        check("max_len", 32'(len));

        // Reset 50 cycles into HIGH.
        repeat (50) @(negedge clk);
        push(1); check("rst_pre_pw", 32'(sonar_pw));
        reset = 1'b1;
        @(negedge clk);
        push(0); check("rst_mid_pw", 32'(sonar_pw));
        push(0); check("rst_mid_fs", 32'(frame_start));
        reset = 1'b0;
        push(0);  avs_rd(2'd3, rd); check("rst_mid_status", rd);
        push(6);  avs_rd(2'd1, rd); check("rst_mid_dist", rd);
        push(DP); avs_rd(2'd2, rd); check("rst_mid_period", rd);

        // Fresh run after reset; noise builds add the reference LFSR jitter.
        model = 16'hACE1;
        avs_wr(2'd1, 32'd10);
        avs_wr(2'd0, 32'd1);
        for (int f = 0; f < 2; f++) begin
            model   = lfsr_step(model);
`ifdef SONAR_EMU_NOISE_EN
            want_hi = 100 + int'(model[7:0]);
`else
            want_hi = 100;
`endif
            push(32'(want_hi));
            push(32'((want_hi + 1 > 200) ? want_hi + 1 : 200));
            measure_frame(1'b0, 0, 2'd0, 32'd0, hi, len);
            check("noise_high", 32'(hi));
            check("noise_len", 32'(len));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sonar_pw_emulator.md
SONAR_PW_EMULATOR -- requirements
Module: sonar_pw_emulator

Interface
REQ-001 SHALL have parameter CLKS_PER_INCH, default 7350, clk cycles per inch of echo pulse (147 us at 50 MHz).
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 2450000, frame period in clk cycles after reset (49 ms).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port avs_address, input, 2, Avalon-MM word address.
REQ-006 SHALL have port avs_read, input, 1, read strobe.
REQ-007 SHALL have port avs_readdata, output, 32, read data.
REQ-008 SHALL have port avs_write, input, 1, write strobe.
REQ-009 SHALL have port avs_writedata, input, 32, write data.
REQ-010 SHALL have port sonar_pw, output, 1, emulated sonar pulse-width echo, the stimulus end of the rangefinder input.
REQ-011 SHALL have port frame_start, output, 1, one-cycle pulse on each frame's first cycle.

Function
REQ-012 SHALL decode registers: 0 CTRL (bit0 enable, bit1 one-shot), 1 DISTANCE (bits 8:0, inches), 2 PERIOD (32-bit clk cycles), 3 STATUS (read-only: bit0 busy, bits 31:16 frame count).
REQ-013 SHALL return avs_readdata one cycle after avs_read (fixed read latency 1), unused bits zero; writes to STATUS ignored.
REQ-014 SHALL clamp DISTANCE on write: values below 6 store 6, above 254 store 254.
REQ-015 SHALL run FSM IDLE -> HIGH -> LOW -> HIGH ... ; IDLE exits to HIGH on the cycle after enable is 1.
REQ-016 SHALL, on HIGH entry, latch DISTANCE and PERIOD into shadows, pulse frame_start, and increment frame count (16-bit, wraps 0xFFFF -> 0x0000).
REQ-017 SHALL hold sonar_pw=1 for exactly shadow_distance*CLKS_PER_INCH cycles in HIGH, then 0 in LOW.
REQ-018 SHALL make frame length max(shadow_period, high_cycles+1), measured from HIGH entry to the next HIGH entry; LOW therefore always lasts at least 1 cycle.
REQ-019 SHALL apply DISTANCE/PERIOD writes made mid-frame only at the next frame start.
REQ-020 SHALL, with one-shot=1, return to IDLE at the end of LOW and clear CTRL.enable in the same cycle.
REQ-021 SHALL, when enable is written 0 in any state, drive sonar_pw=0 and go to IDLE on the next cycle, aborting the frame.
REQ-022 SHALL report busy=1 whenever FSM is not IDLE.
REQ-023 SHALL size the high-time counter to hold 254*CLKS_PER_INCH and the frame counter to 32 bits.

Reset
REQ-024 SHALL, on reset, set FSM IDLE, sonar_pw=0, frame_start=0, avs_readdata=0, CTRL=0, DISTANCE=6, PERIOD=DEFAULT_PERIOD, frame count=0.
REQ-025 SHALL let reset asserted mid-frame take effect on the next edge with no residual pulse.

Configuration
REQ-026 SHALL, with SONAR_EMU_NOISE_EN defined, include a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 0xACE1) advanced once per frame start, adding lfsr[7:0] extra cycles to each frame's high time.
REQ-027 SHALL, without SONAR_EMU_NOISE_EN, contain no LFSR; high time exactly per REQ-017.

Verification (CLKS_PER_INCH=10, DEFAULT_PERIOD=200, noise off unless stated)
REQ-028 SHALL cover: write DISTANCE=10, CTRL=1 -> sonar_pw high 100 cycles, frames every 200 cycles, frame_start once per frame.
REQ-029 SHALL cover: write DISTANCE=2, then 300 -> readback 6 and 254; DISTANCE=254, PERIOD=200 -> frame length 2541 cycles.
REQ-030 SHALL cover: DISTANCE=20 written during HIGH of a 10-inch frame -> current pulse 100 cycles, next 200.
REQ-031 SHALL cover: CTRL=3 -> exactly one 100-cycle pulse, then busy=0, CTRL reads 0, frame count 1.
REQ-032 SHALL cover: enable cleared or reset asserted 50 cycles into HIGH -> sonar_pw 0 next cycle, busy 0.
REQ-033 SHALL cover: SONAR_EMU_NOISE_EN defined, DISTANCE=10 -> first pulse length 100+lfsr[7:0] from the post-seed advance, matching a reference LFSR model.
